multi_cpu_control_unit: RTL and testbench



---
 rtl/multi_cpu_control_unit.sv | 171 +++++++++++++++++
 tb/tb_multi_cpu_control_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cpu_control_unit.sv
// multi_cpu_control_unit: instruction-phase FSM and control decoder for the
// multi-cycle MIPS-subset CPU. The state register is the only flop; every
// control line is decoded combinationally from State, opcode, zero and sign.
// Optional feature macro: CU_BRANCH_EXT_EN adds bne and bltz. Without it
// those two opcodes decode as unknown (a two-cycle nop). beq is always present.
module multi_cpu_control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] State,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic [1:0] PCSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc
);

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_AEXE = 3'b110;
    localparam logic [2:0] S_BEXE = 3'b101;
    localparam logic [2:0] S_CEXE = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_AWB  = 3'b111;
    localparam logic [2:0] S_CWB  = 3'b100;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
    logic is_rtype, is_itype, is_alu;
    logic is_sw, is_lw, is_mem;
    logic is_beq, is_bne, is_bltz, is_branch, branch_taken;
    logic is_j, is_jr, is_jal, is_halt;

    // Opcode decode into instruction-class flags; bne/bltz exist only with the extension macro
    always_comb begin
        is_sub   = (opcode == OP_SUB);
        is_addi  = (opcode == OP_ADDI);
        is_or    = (opcode == OP_OR);
        is_and   = (opcode == OP_AND);
        is_ori   = (opcode == OP_ORI);
        is_sll   = (opcode == OP_SLL);
        is_slt   = (opcode == OP_SLT);
        is_rtype = (opcode == OP_ADD) | is_sub | is_or | is_and | is_sll | is_slt;
        is_itype = is_addi | is_ori;
        is_alu   = is_rtype | is_itype;
        is_sw    = (opcode == OP_SW);
        is_lw    = (opcode == OP_LW);
        is_mem   = is_sw | is_lw;
        is_beq   = (opcode == OP_BEQ);
`ifdef CU_BRANCH_EXT_EN
        is_bne   = (opcode == OP_BNE);
        is_bltz  = (opcode == OP_BLTZ);
`else
        is_bne   = 1'b0;
        is_bltz  = 1'b0;
`endif
        is_branch    = is_beq | is_bne | is_bltz;
        branch_taken = (is_beq & zero) | (is_bne & ~zero) | (is_bltz & sign);
        is_j     = (opcode == OP_J);
        is_jr    = (opcode == OP_JR);
        is_jal   = (opcode == OP_JAL);
        is_halt  = (opcode == OP_HALT);
    end

    // Next-state logic; jumps and unknown opcodes finish in ID, halt parks in ID
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (is_halt)        state_d = S_ID;
                else if (is_alu)    state_d = S_AEXE;
                else if (is_branch) state_d = S_BEXE;
                else if (is_mem)    state_d = S_CEXE;
                else                state_d = S_IF;
            end
            S_AEXE: state_d = S_AWB;
            S_CEXE: state_d = S_MEM;
            S_MEM:  state_d = is_lw ? S_CWB : S_IF;
            default: state_d = S_IF;
        endcase
    end

    // State register, forced to IF asynchronously while reset is held low
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    assign State = state_q;

    // Control decode: steering lines held from ID to the end of the instruction, enables per state
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b1;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        PCSrc     = 2'b00;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        if (state_q == S_IF) begin
            IRWre = 1'b1;
        end else begin
            ALUSrcA   = is_sll;
            ALUSrcB   = is_itype | is_mem;
            ExtSel    = is_addi | is_mem | is_branch;
            WrRegDSrc = is_alu | is_lw;
            DBDataSrc = is_lw;
            if (is_rtype)              RegDst = 2'b10;
            else if (is_itype | is_lw) RegDst = 2'b01;
            if (is_sub | is_branch)    ALUOp = 3'b001;
            else if (is_sll)           ALUOp = 3'b010;
            else if (is_or | is_ori)   ALUOp = 3'b011;
            else if (is_and)           ALUOp = 3'b100;
            else if (is_slt)           ALUOp = 3'b110;
            if (is_j | is_jal)         PCSrc = 2'b11;
            else if (is_jr)            PCSrc = 2'b10;
            else if ((state_q == S_BEXE) && branch_taken) PCSrc = 2'b01;
            PCWre  = (state_d == S_IF);
            RegWre = (state_q == S_AWB) | (state_q == S_CWB) | ((state_q == S_ID) & is_jal);
            mRD    = ((state_q == S_MEM) | (state_q == S_CWB)) & is_lw;
            mWR    = (state_q == S_MEM) & is_sw;
        end
        if (!Reset) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cpu_control_unit.sv
// Testbench for multi_cpu_control_unit: a per-cycle table of inputs and
// hand-computed control words, plus hand sequences for halt and async reset.
// Expectations for bne/bltz follow CU_BRANCH_EXT_EN.
module tb_multi_cpu_control_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic [2:0] State;
    logic       PCWre, IRWre, InsMemRW, RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtSel;
    logic [1:0] PCSrc;
    logic       mRD, mWR, DBDataSrc;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110;
    localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
    localparam logic [5:0] BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
    localparam logic [5:0] HALT = 6'b111111, UNK = 6'b101010;

    // Control word layout:
    // {State, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, PCSrc, mRD, mWR, DBDataSrc}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        s;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;

    multi_cpu_control_unit dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .State(State), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc)
    );

    function automatic logic [20:0] actualWord();
        return {State, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
                ALUSrcA, ALUSrcB, ALUOp, ExtSel, PCSrc, mRD, mWR, DBDataSrc};
    endfunction

    // Append one raw per-cycle vector
    task automatic addVec(input logic rst, input logic [5:0] op, input logic z, input logic s,
                          input logic [2:0] st, input logic pcw, input logic irw, input logic rw,
                          input logic [1:0] rdst, input logic wsrc, input logic asa, input logic asb,
                          input logic [2:0] alu, input logic ext, input logic [1:0] pcs,
                          input logic mrd, input logic mwr, input logic dbs);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.z   = z;
        v.s   = s;
        v.exp = {st, pcw, irw, 1'b1, rw, rdst, wsrc, asa, asb, alu, ext, pcs, mrd, mwr, dbs};
        vecs.push_back(v);
    endtask

    // IF cycle: only IRWre and InsMemRW high, whatever the (stale) opcode is
    task automatic vIf(input logic [5:0] op);
        addVec(1'b1, op, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
               3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Non-IF cycle with reset released
    task automatic vCtl(input logic [2:0] st, input logic [5:0] op, input logic z, input logic s,
                        input logic pcw, input logic rw, input logic [1:0] rdst, input logic wsrc,
                        input logic asa, input logic asb, input logic [2:0] alu, input logic ext,
                        input logic [1:0] pcs, input logic mrd, input logic mwr, input logic dbs);
        addVec(1'b1, op, z, s, st, pcw, 1'b0, rw, rdst, wsrc, asa, asb, alu, ext, pcs, mrd, mwr, dbs);
    endtask

    // Four-cycle ALU instruction: IF, ID, aEXE, aWB
    task automatic aluInstr(input logic [5:0] op, input logic [1:0] rdst, input logic asa,
                            input logic asb, input logic [2:0] alu, input logic ext);
        vIf(op);
        vCtl(3'b001, op, 1'b0, 1'b0, 1'b0, 1'b0, rdst, 1'b1, asa, asb, alu, ext, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b110, op, 1'b0, 1'b0, 1'b0, 1'b0, rdst, 1'b1, asa, asb, alu, ext, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b111, op, 1'b0, 1'b0, 1'b1, 1'b1, rdst, 1'b1, asa, asb, alu, ext, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset-held cycle: IF values with every write enable and IRWre forced low
    task automatic vReset(input logic [5:0] op);
        addVec(1'b0, op, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
               3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        Reset  = v.rst;
        opcode = v.op;
        zero   = v.z;
        sign   = v.s;
    endtask

    task automatic checkOutput(input string name, input logic [20:0] got, input logic [20:0] want);
        applied++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus: build the table, run it, then the halt and async-reset sequences
    initial begin
        Reset  = 1'b1;
        opcode = ADD;
        zero   = 1'b0;
        sign   = 1'b0;
        #1 Reset = 1'b0;

        vReset(ADD);
        vReset(ADD);
        aluInstr(ADD,  2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
        aluInstr(SUB,  2'b10, 1'b0, 1'b0, 3'b001, 1'b0);
        aluInstr(ADDI, 2'b01, 1'b0, 1'b1, 3'b000, 1'b1);
        aluInstr(ORI,  2'b01, 1'b0, 1'b1, 3'b011, 1'b0);
        aluInstr(SLL,  2'b10, 1'b1, 1'b0, 3'b010, 1'b0);
        aluInstr(SLT,  2'b10, 1'b0, 1'b0, 3'b110, 1'b0);

        vIf(LW);
        vCtl(3'b001, LW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        vCtl(3'b010, LW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        vCtl(3'b011, LW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        vCtl(3'b100, LW, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);

        vIf(SW);
        vCtl(3'b001, SW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b010, SW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b011, SW, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);

        vIf(BEQ);
        vCtl(3'b001, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b101, BEQ, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        vIf(BEQ);
        vCtl(3'b001, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b101, BEQ, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef CU_BRANCH_EXT_EN
        vIf(BNE);
        vCtl(3'b001, BNE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b101, BNE, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        vIf(BLTZ);
        vCtl(3'b001, BLTZ, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b101, BLTZ, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        vIf(BLTZ);
        vCtl(3'b001, BLTZ, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b101, BLTZ, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
`else
        vIf(BNE);
        vCtl(3'b001, BNE, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        vIf(BLTZ);
        vCtl(3'b001, BLTZ, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`endif

        vIf(JAL);
        vCtl(3'b001, JAL, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        vIf(JR);
        vCtl(3'b001, JR, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        vIf(J);
        vCtl(3'b001, J, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        vIf(UNK);
        vCtl(3'b001, UNK, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // sw aborted by reset dropping in MEM, then restart into halt
        vIf(SW);
        vCtl(3'b001, SW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vCtl(3'b010, SW, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        vReset(SW);
        vReset(SW);
        vIf(HALT);

        @(posedge CLK);
        foreach (vecs[i]) begin
            #2 applyStimulus(vecs[i]);
            #1 checkOutput($sformatf("vec%0d op=%b", i, vecs[i].op), actualWord(), vecs[i].exp);
            @(posedge CLK);
        end

        // Halt parks in ID with no PC update
        for (int k = 0; k < 20; k++) begin
            #3 checkOutput($sformatf("halt cycle%0d State,PCWre", k), {17'd0, State, PCWre}, 21'b0010);
            @(posedge CLK);
        end

        // Reset while halted: State returns to IF without any clock edge
        #2 Reset = 1'b0;
        #1 checkOutput("halt async reset State,PCWre,IRWre,RegWre,mRD,mWR",
                       {13'd0, State, PCWre, IRWre, RegWre, mRD, mWR}, 21'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
